// File: rtl/grid_loader_if.sv
// Stream-in, memory write port and status bundle for grid_loader.
// No timing of its own; registers live in the loader.
// Source drives start/in_*, loader owns in_ready and every result signal.
interface grid_loader_if #(
  parameter int ADDR_W = 17
);
  logic              start;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [ADDR_W-1:0] write_addr;
  logic              write_val;
  logic              write_en;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   grid_cols;
  logic [ADDR_W:0]   grid_rows;
  logic [ADDR_W:0]   ones_count;

  // Environment side: byte source, memory sink and solver
  modport master (
    output start, in_data, in_valid, in_last,
    input  in_ready, write_addr, write_val, write_en, done, error,
           grid_cols, grid_rows, ones_count
  );

  // Loader side
  modport slave (
    input  start, in_data, in_valid, in_last,
    output in_ready, write_addr, write_val, write_en, done, error,
           grid_cols, grid_rows, ones_count
  );
endinterface

// File: rtl/grid_loader.sv
// Parses an ASCII '@'/'.' grid stream into row-major 1-bit memory writes and grid stats.
// Latency: write strobe, done and error are registered, one cycle after the accepting edge.
// Backpressure: in_ready is high for the whole LOAD state, one byte per cycle, never stalls.
// Build option GRID_LOADER_CR_SKIP_EN: '\r' is skipped (CRLF input) instead of being illegal.
module grid_loader #(
  parameter int ADDR_W = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  grid_loader_if.slave bus
);

  localparam logic [7:0] CH_AT  = 8'h40;
  localparam logic [7:0] CH_DOT = 8'h2E;
  localparam logic [7:0] CH_LF  = 8'h0A;
`ifdef GRID_LOADER_CR_SKIP_EN
  localparam logic [7:0] CH_CR  = 8'h0D;
`endif
  localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);
  localparam logic [ADDR_W:0]   ONE_C = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE,
    ST_ERROR
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic              full, full_nxt;
  logic [ADDR_W:0]   col, col_nxt;
  logic [ADDR_W:0]   cols, cols_nxt;
  logic [ADDR_W:0]   rows, rows_nxt;
  logic [ADDR_W:0]   ones, ones_nxt;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_nxt;
  logic              wr_val_q, wr_val_nxt;
  logic              wr_en_q, wr_en_nxt;
  logic              is_cell;
  logic              is_nl;
  logic              is_skip;
  logic              bad;

  // Next-state and datapath: classify the byte, write cells, close lines, pick the exit state
  always_comb begin
    state_nxt   = state;
    addr_nxt    = addr;
    full_nxt    = full;
    col_nxt     = col;
    cols_nxt    = cols;
    rows_nxt    = rows;
    ones_nxt    = ones;
    wr_addr_nxt = wr_addr_q;
    wr_val_nxt  = wr_val_q;
    wr_en_nxt   = 1'b0;
    is_cell     = (bus.in_data == CH_AT) || (bus.in_data == CH_DOT);
    is_nl       = (bus.in_data == CH_LF);
`ifdef GRID_LOADER_CR_SKIP_EN
    is_skip     = (bus.in_data == CH_CR);
`else
    is_skip     = 1'b0;
`endif
    bad         = 1'b0;

    unique case (state)
      ST_LOAD: begin
        if (bus.in_valid) begin
          if (is_cell) begin
            // Once addr has wrapped, every cell slot is used: refuse rather than overwrite
            if (full) begin
              bad = 1'b1;
            end else begin
              wr_en_nxt   = 1'b1;
              wr_addr_nxt = addr;
              wr_val_nxt  = (bus.in_data == CH_AT);
              addr_nxt    = addr + ONE_A;
              if (addr == '1) full_nxt = 1'b1;
              col_nxt = col + ONE_C;
              if (bus.in_data == CH_AT) ones_nxt = ones + ONE_C;
            end
          end else if (!is_nl && !is_skip) begin
            bad = 1'b1;
          end

          // A '\n' or the final byte closes a non-empty line; the first line fixes the width
          if (!bad && (is_nl || bus.in_last) && (col_nxt != '0)) begin
            if (rows == '0) begin
              cols_nxt = col_nxt;
              rows_nxt = ONE_C;
              col_nxt  = '0;
            end else if (col_nxt == cols) begin
              rows_nxt = rows + ONE_C;
              col_nxt  = '0;
            end else begin
              bad = 1'b1;
            end
          end

          if (bad) begin
            state_nxt = ST_ERROR;
          end else if (bus.in_last) begin
            state_nxt = ST_DONE;
          end
        end
      end
      default: begin
        // IDLE, DONE and ERROR all wait for start; status is derived from state, so it clears too
        if (bus.start) begin
          addr_nxt  = '0;
          full_nxt  = 1'b0;
          col_nxt   = '0;
          cols_nxt  = '0;
          rows_nxt  = '0;
          ones_nxt  = '0;
          state_nxt = ST_LOAD;
        end
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Address, line and count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
      full <= 1'b0;
      col  <= '0;
      cols <= '0;
      rows <= '0;
      ones <= '0;
    end else begin
      addr <= addr_nxt;
      full <= full_nxt;
      col  <= col_nxt;
      cols <= cols_nxt;
      rows <= rows_nxt;
      ones <= ones_nxt;
    end
  end

  // Registered memory write port; strobe lasts exactly one cycle per accepted cell
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_q <= '0;
      wr_val_q  <= 1'b0;
      wr_en_q   <= 1'b0;
    end else begin
      wr_addr_q <= wr_addr_nxt;
      wr_val_q  <= wr_val_nxt;
      wr_en_q   <= wr_en_nxt;
    end
  end

  assign bus.in_ready   = (state == ST_LOAD);
  assign bus.done       = (state == ST_DONE);
  assign bus.error      = (state == ST_ERROR);
  assign bus.write_addr = wr_addr_q;
  assign bus.write_val  = wr_val_q;
  assign bus.write_en   = wr_en_q;
  assign bus.grid_cols  = cols;
  assign bus.grid_rows  = rows;
  assign bus.ones_count = ones;

endmodule

// File: doc/grid_loader.md
# grid_loader

Upstream load stage for the 1-bit simple dual-port grid memory. Parses an ASCII puzzle grid arriving as a valid/ready byte stream: '@' is an occupied cell (1) and '.' is an empty cell (0). It writes cells in row-major order to consecutive memory addresses on the memory's write port. It learns the grid width from the first line, checks that every later line matches it, and reports rows, columns and occupied-cell count to the downstream solver.

## Interface
- ADDR_W, 17, memory address width; capacity 2^ADDR_W cells
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse; begins a new load from IDLE, DONE or ERROR
- in_data  in  8  ASCII byte
- in_valid  in  1  in_data valid
- in_last  in  1  qualifies in_data as the final byte of the grid
- in_ready  out  1  byte accepted when in_valid & in_ready
- write_addr  out  ADDR_W  cell address, connects to memory write_addr
- write_val  out  1  cell value
- write_en  out  1  single-cycle write strobe
- done  out  1  load completed without error; held
- error  out  1  load aborted; held
- grid_cols  out  ADDR_W+1  cells per row
- grid_rows  out  ADDR_W+1  row count
- ones_count  out  ADDR_W+1  number of '@' cells

## Operation
- States are IDLE, LOAD, DONE and ERROR; reset enters IDLE.
- IDLE/DONE/ERROR + start: clear addr, col, cols, rows and ones; clear done and error; go to LOAD. Otherwise hold.
- start is ignored while in LOAD.
- in_ready = (state == LOAD).
- Each accepted byte in LOAD is handled as follows:
  - '@' (0x40): write 1 at addr; addr++, col++, ones++.
  - '.' (0x2E): write 0 at addr; addr++, col++.
  - '\n' (0x0A), col == 0: blank line; ignored, no state change.
  - '\n', col != 0, rows == 0: cols <= col; rows <= 1; col <= 0.
  - '\n', col != 0, rows > 0: if col == cols, rows++ and col <= 0; else go to ERROR.
  - Any other byte: go to ERROR with no write.
- Capacity: a cell byte arriving after 2^ADDR_W cells have been written goes to ERROR with no write. An internal full flag is set when addr wraps to 0.
- First row longer than its final width cannot occur: width is fixed at the first '\n'.
- Every later row is checked at its '\n'.
- in_last: the byte is processed as above. If no error results and col != 0 afterwards, the pending line is closed with the same '\n' rules. Then go to DONE, or to ERROR if that check fails.
- in_last on a file containing zero cells goes to DONE with all counts 0.
- Writes already issued before an error are not retracted.
- grid_cols, grid_rows and ones_count are valid when done = 1. They hold until the next start.

## Timing
- write_addr, write_val and write_en are registered: write_en is high exactly one cycle, in the cycle after the accepting edge.
- Throughput is one byte per cycle; in_valid gaps are allowed.
- done and error assert in the cycle after the accepting edge of the terminating or offending byte. in_ready deasserts in that same cycle.
- start and in_valid in the same cycle in IDLE: start wins and no byte is accepted (in_ready is low).
- Reset, asynchronous at any time including mid-load: state IDLE; in_ready, write_en, write_val, write_addr, done, error and all counts are 0.
- Memory-side input registering adds one cycle before the write lands. The downstream solver must not read the grid before done.

## Configuration
- GRID_LOADER_CR_SKIP_EN
  - Defined: '\r' (0x0D) is accepted and ignored, so CRLF files load identically to LF files.
  - Undefined: '\r' is an illegal byte and goes to ERROR.

## Test plan
- "@.@\n.@.\n", in_last on the final '\n' -> six writes at addr 0..5 with values 1,0,1,0,1,0; done = 1; cols = 3, rows = 2, ones = 3.
- "@@\n@\n" -> writes at addr 0..2; error = 1 the cycle after the second '\n'; done = 0; in_ready = 0.
- "@.\n.@", in_last on the final '@' (no trailing newline) -> done; cols = 2, rows = 2, ones = 2.
- "@x" -> one write (addr 0, value 1); error after 'x'; write_en stays low for 'x'. A new start clears error and the counters.
- "@.\r\n" with in_last -> macro defined: done, cols = 2, rows = 1. Undefined: error after '\r'.
- ADDR_W = 3, stream of 9 '.' bytes -> 8 writes at addr 0..7, then error on the 9th byte. Separately, rst_n low mid-stream -> all outputs 0 asynchronously and the block stays IDLE until start.
